muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative M-extension execute unit and sequencer for the RV32IM_Zbb core.
- Sits beside the ALU in the execute stage. Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation per handshake.
- Runs a 32-step shift-add / restoring-divide loop, applies the sign fixup, and holds the result until the writeback side takes it.
- Stalls the pipeline through ready_o/busy_o. Supports flush for branch mispredict or trap.

Parameters:
XLEN  32  operand/result width; only 32 is supported
EARLY_OUT  1  1 = divide-by-zero and signed-overflow cases complete on the fast path; 0 = they run the full loop and produce the same values

Ports:
clk_i  input  1  clock, rising-edge
rst_ni  input  1  asynchronous active-low reset
valid_i  input  1  operation request
op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_i  input  32  operand A (dividend / multiplicand)
rs2_i  input  32  operand B (divisor / multiplier)
ready_o  output  1  unit can accept (state IDLE)
busy_o  output  1  state != IDLE
valid_o  output  1  result_o valid (state DONE)
result_o  output  32  result
result_ready_i  input  1  consumer accepts result
flush_i  input  1  abort current operation

Behaviour:
- Reset (async, rst_ni=0): state IDLE, counter 0, all datapath registers 0.
  - Outputs during reset: ready_o=1, busy_o=0, valid_o=0, result_o=0.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE. Fast path: IDLE -> DONE.
  - ready_o = (state==IDLE), combinational.
  - valid_o = (state==DONE), registered state.
- Accept: rising edge with state IDLE, valid_i=1, flush_i=0.
  - Latches op_i, magnitudes of operands, and the result sign.
  - Signed operands: DIV/REM/MULH use rs1 and rs2 signed. MULHSU uses rs1 signed, rs2 unsigned. MUL/DIVU/REMU/MULHU are unsigned.
  - Negative operands are converted to magnitude (two's complement).
- CALC: 5-bit counter, one step per edge, 32 steps; the step with counter==31 moves to FIX.
  - Multiply: 64-bit accumulator; each step adds the shifted multiplicand if the current multiplier bit is 1.
  - Divide: restoring. Shift the remainder left, bring in the next dividend bit, subtract the divisor if no borrow, set the quotient bit.
- FIX (1 cycle): negate the 64-bit product, quotient or remainder as required; select result_o.
  - Product negated if signs differ.
  - Quotient negated if signs differ.
  - Remainder takes the dividend sign.
  - MUL returns low 32 bits; MULH/MULHSU/MULHU return high 32 bits.
- Latency: valid_o first high in the 33rd cycle after the accept edge (32 CALC + 1 FIX).
- Fast path (EARLY_OUT=1), decided at the accept edge; goes directly to DONE, valid_o high the next cycle.
  - rs2==0: DIV/DIVU result 0xFFFFFFFF; REM/REMU result rs1.
  - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: DIV result 0x80000000, REM result 0.
  - Multiplies never take the fast path.
- DONE: result_o held stable while result_ready_i=0.
  - Edge with result_ready_i=1 returns to IDLE.
  - A new request cannot be accepted in the same cycle; ready_o stays 0 in DONE.
- valid_i while not IDLE: ignored. Requester must hold valid_i until it sees ready_o.
- flush_i=1 at any edge: go to IDLE and clear the counter.
  - Flush beats valid_i (no accept) and beats result_ready_i.
  - valid_o=0 from the next cycle; a flushed op never produces valid_o.
- result_o changes only on the FIX or fast-path edge. It keeps its last value in IDLE; it is not cleared.
- Async reset mid-operation: immediate IDLE and reset values; no result produced.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB, valid_o exactly 33 cycles after accept, busy_o high throughout.
- High multiplies:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Divides:
  - DIV -7/2 -> 0xFFFFFFFD; REM -7%2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100%7 -> 2.
  - DIV 7/-2 -> 0xFFFFFFFD; REM 7%-2 -> 1.
- Corner cases:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
  - Each gives valid_o 1 cycle after accept with EARLY_OUT=1, and the same values after 33 cycles with EARLY_OUT=0.
- Backpressure: hold result_ready_i=0 for 5 cycles after valid_o -> result_o stable, ready_o=0, a valid_i pulse is ignored.
  - Raise result_ready_i -> IDLE next cycle, ready_o=1.
- Flush and reset:
  - flush_i at CALC step 10 of DIVU -> IDLE next cycle, no valid_o.
  - Same-cycle flush_i+valid_i in IDLE -> no accept.
  - rst_ni low mid-CALC -> outputs at reset values immediately.
  - Next MUL 3x4 -> 12.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/response bus between the execute-stage sequencer and the iterative M-extension unit.
interface muldiv_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            valid_i;
   logic [2:0]      op_i;
   logic [XLEN-1:0] rs1_i;
   logic [XLEN-1:0] rs2_i;
   logic            ready_o;
   logic            busy_o;
   logic            valid_o;
   logic [XLEN-1:0] result_o;
   logic            result_ready_i;
   logic            flush_i;

   modport master (
      output valid_i, op_i, rs1_i, rs2_i, result_ready_i, flush_i,
      input  ready_o, busy_o, valid_o, result_o
   );

   modport slave (
      input  valid_i, op_i, rs1_i, rs2_i, result_ready_i, flush_i,
      output ready_o, busy_o, valid_o, result_o
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add / restoring divide with sign fixup.
module muldiv_unit #(
   parameter int unsigned XLEN      = 32,
   parameter bit          EARLY_OUT = 1'b1
) (
   input logic          clk_i,
   input logic          rst_ni,
   muldiv_unit_if.slave bus
);
   localparam int unsigned CW = 5;
   localparam int unsigned PW = 2 * XLEN;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      op_q, op_d;
   logic [XLEN-1:0] a_q, a_d;      // multiplicand / dividend, then quotient
   logic [XLEN-1:0] b_q, b_d;      // multiplier (shifts right) / divisor
   logic [PW-1:0]   acc_q, acc_d;  // product, or remainder in the low half
   logic [PW-1:0]   sh_q, sh_d;    // multiplicand shifted to the current bit weight
   logic [XLEN-1:0] res_q, res_d;
   logic            neg_res_q, neg_res_d;
   logic            neg_rem_q, neg_rem_d;

   logic            is_div, rs1_signed, rs2_signed, a_neg, b_neg;
   logic            rs2_zero, ovf, fast;
   logic [XLEN-1:0] a_mag, b_mag, fast_res;
   logic [XLEN:0]   trial;
   logic [PW-1:0]   prod;

   // Operand decode at the accept edge
   assign is_div     = bus.op_i[2];
   assign rs1_signed = (bus.op_i == OP_MULH) || (bus.op_i == OP_MULHSU) ||
                       (bus.op_i == OP_DIV)  || (bus.op_i == OP_REM);
   assign rs2_signed = (bus.op_i == OP_MULH) || (bus.op_i == OP_DIV) || (bus.op_i == OP_REM);
   assign a_neg      = rs1_signed & bus.rs1_i[XLEN-1];
   assign b_neg      = rs2_signed & bus.rs2_i[XLEN-1];
   assign a_mag      = a_neg ? -bus.rs1_i : bus.rs1_i;
   assign b_mag      = b_neg ? -bus.rs2_i : bus.rs2_i;
   assign rs2_zero   = (bus.rs2_i == '0);
   assign ovf        = is_div & ~bus.op_i[0] &
                       (bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (bus.rs2_i == '1);
   assign fast       = EARLY_OUT & is_div & (rs2_zero | ovf);
   // Overflow quotient equals the dividend itself (0x80000000)
   assign fast_res   = rs2_zero ? (bus.op_i[1] ? bus.rs1_i : '1)
                                : (bus.op_i[1] ? '0 : bus.rs1_i);

   assign trial = {acc_q[XLEN-1:0], a_q[XLEN-1]} - {1'b0, b_q};
   assign prod  = neg_res_q ? -acc_q : acc_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      sh_d      = sh_q;
      res_d     = res_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      if (bus.flush_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.valid_i) begin
                  op_d      = bus.op_i;
                  a_d       = a_mag;
                  b_d       = b_mag;
                  acc_d     = '0;
                  sh_d      = {{XLEN{1'b0}}, a_mag};
                  cnt_d     = '0;
                  // Divide-by-zero keeps the all-ones quotient unnegated on the full loop too
                  neg_res_d = (a_neg ^ b_neg) & ~(is_div & rs2_zero);
                  neg_rem_d = a_neg;
                  if (fast) begin
                     res_d   = fast_res;
                     state_d = DONE;
                  end else begin
                     state_d = CALC;
                  end
               end
            end
            CALC: begin
               cnt_d = cnt_q + CW'(1);
               if (op_q[2]) begin
                  if (!trial[XLEN]) acc_d = {{XLEN{1'b0}}, trial[XLEN-1:0]};
                  else              acc_d = {{XLEN{1'b0}}, acc_q[XLEN-2:0], a_q[XLEN-1]};
                  a_d = {a_q[XLEN-2:0], ~trial[XLEN]};
               end else begin
                  if (b_q[0]) acc_d = acc_q + sh_q;
                  sh_d = sh_q << 1;
                  b_d  = b_q >> 1;
               end
               if (cnt_q == CW'(XLEN-1)) state_d = FIX;
            end
            FIX: begin
               case (op_q)
                  OP_MUL:                      res_d = prod[XLEN-1:0];
                  OP_MULH, OP_MULHSU, OP_MULHU: res_d = prod[PW-1:XLEN];
                  OP_DIV, OP_DIVU:             res_d = neg_res_q ? -a_q : a_q;
                  default:                     res_d = neg_rem_q ? -acc_q[XLEN-1:0]
                                                                 : acc_q[XLEN-1:0];
               endcase
               state_d = DONE;
            end
            DONE: begin
               if (bus.result_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         sh_q      <= '0;
         res_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         sh_q      <= sh_d;
         res_q     <= res_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
      end
   end

   assign bus.ready_o  = (state_q == IDLE);
   assign bus.busy_o   = (state_q != IDLE);
   assign bus.valid_o  = (state_q == DONE);
   assign bus.result_o = res_q;
endmodule
